// File: rtl/legv8_imm_pkg.sv
// LEGv8 immediate field layout shared by the encoder and the sign-extend side.
// Latency: n/a (constants only).
// Backpressure: n/a.
package legv8_imm_pkg;

  // opCode selects which instruction format's immediate field is written
  localparam logic [1:0] OP_D    = 2'b00;
  localparam logic [1:0] OP_CB   = 2'b01;
  localparam logic [1:0] OP_B    = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  // D format: DT_address, bits 20:12
  localparam int D_LSB  = 12;
  localparam int D_W    = 9;
  // CB format: COND_BR_address, bits 23:5
  localparam int CB_LSB = 5;
  localparam int CB_W   = 19;
  // B format: BR_address, bits 25:0
  localparam int B_LSB  = 0;
  localparam int B_W    = 26;

endpackage

// File: rtl/imm_range_check.sv
// Flags whether a signed value survives truncation to an N-bit two's-complement field.
// Latency: combinational.
// Backpressure: none (pure function of imm).
module imm_range_check #(
  parameter int DATA_W = 64,
  parameter int N      = 9
) (
  input  logic [DATA_W-1:0] imm,
  output logic              fits
);

  // The value fits when re-sign-extending its low N bits gives it back unchanged,
  // i.e. every bit from N-1 upward is a copy of the field's sign bit.
  assign fits = (imm == {{(DATA_W-N){imm[N-1]}}, imm[N-1:0]});

endmodule

// File: rtl/imm_field_encoder.sv
// Packs a signed offset into the D/CB/B immediate field of an instruction word, flags overflow.
// Latency: 2 cycles accept-to-output when unstalled; one beat per cycle.
// Backpressure: skid-free 2-stage pipe; in_ready follows out_ready combinationally, 2 beats max held.
module imm_field_encoder
  import legv8_imm_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32,
  parameter int ERRC_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         opCode,
  input  logic [DATA_W-1:0]  imm,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out,
  output logic               out_range_err,
  output logic [ERRC_W-1:0]  err_count
);

  logic               s1_valid;
  logic [1:0]         s1_op;
  logic [DATA_W-1:0]  s1_imm;
  logic [INSTR_W-1:0] s1_instr;
  logic               s2_valid;
  logic               s1_adv;
  logic               s2_adv;
  logic               fit_d;
  logic               fit_cb;
  logic               fit_b;
  logic               s1_fit;
  logic [INSTR_W-1:0] fmask;
  logic [INSTR_W-1:0] fval;
  logic [INSTR_W-1:0] nxt_out;
  logic               nxt_err;

  // A stage may load when it is empty or the stage after it is moving.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  imm_range_check #(.DATA_W(DATA_W), .N(D_W))  u_chk_d  (.imm(s1_imm), .fits(fit_d));
  imm_range_check #(.DATA_W(DATA_W), .N(CB_W)) u_chk_cb (.imm(s1_imm), .fits(fit_cb));
  imm_range_check #(.DATA_W(DATA_W), .N(B_W))  u_chk_b  (.imm(s1_imm), .fits(fit_b));

  // Stage 1 register: capture the beat whenever the input handshake completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_imm   <= '0;
      s1_instr <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op    <= opCode;
        s1_imm   <= imm;
        s1_instr <= instr_in;
      end
    end
  end

  // Select the field position and fit flag for the stage-1 format; pass mode leaves the word alone.
  always_comb begin
    fmask  = '0;
    fval   = '0;
    s1_fit = 1'b1;
    case (s1_op)
      OP_D: begin
        fmask[D_LSB +: D_W] = '1;
        fval[D_LSB +: D_W]  = s1_imm[D_W-1:0];
        s1_fit              = fit_d;
      end
      OP_CB: begin
        fmask[CB_LSB +: CB_W] = '1;
        fval[CB_LSB +: CB_W]  = s1_imm[CB_W-1:0];
        s1_fit                = fit_cb;
      end
      OP_B: begin
        fmask[B_LSB +: B_W] = '1;
        fval[B_LSB +: B_W]  = s1_imm[B_W-1:0];
        s1_fit              = fit_b;
      end
      default: begin
        fmask  = '0;
        fval   = '0;
        s1_fit = 1'b1;
      end
    endcase
    // Truncated low bits are still inserted on overflow so the word stays well-formed.
    nxt_out = (s1_instr & ~fmask) | fval;
    nxt_err = !s1_fit;
  end

  // Stage 2 register: holds the encoded word stable until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      out           <= '0;
      out_range_err <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out           <= nxt_out;
        out_range_err <= nxt_err;
      end
    end
  end

  // Count delivered overflow beats, sticking at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (s2_valid && out_ready && out_range_err && !(&err_count)) begin
      err_count <= err_count + ERRC_W'(1);
    end
  end

endmodule
